dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 161 ++++++++++++++++
 tb/tb_dmem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the 64-bit pipelined MIPS core.
// Doubleword-organised storage that is zeroed by a sequencer after reset,
// answers combinational loads and registered stores. It also enforces
// store alignment, keeps a sticky error flag and a saturating store counter,
// and exposes a debug read port.
module dmem_responder #(
    parameter int N  = 64,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  dataadr,
    input  logic [N-1:0]  writedata,
    input  logic [1:0]    memwriteM,
    input  logic          dtype,
    output logic [N-1:0]  readdata,
    output logic          ready,
    output logic          err,
    output logic [15:0]   storecnt,
    input  logic [AW-1:0] dbgadr,
    output logic [N-1:0]  dbgdata
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int DEPTH = 2 ** AW;

    state_t          state_r;
    state_t          state_s;
    logic [AW-1:0]   clr_idx_r;
    logic            ready_r;
    logic            err_r;
    logic [15:0]     storecnt_r;
    logic [N-1:0]    mem_r [DEPTH];

    logic [AW-1:0]   idx_s;
    logic [N-1:0]    rd_word_s;
    logic            dw_ok_s;
    logic            wd_ok_s;
    logic            commit_s;
    logic            bad_s;
    logic            wr_dw_s;
    logic            wr_lo_s;
    logic            wr_hi_s;
    logic            unused_s;

    // Address bits above the array span only alias; fold them so they are consumed.
    assign unused_s = ^dataadr[N-1:AW+3];

    // Decode the core access: index, alignment and the resulting store decision.
    always_comb begin
        idx_s     = dataadr[AW+2:3];
        rd_word_s = mem_r[idx_s];
        dw_ok_s   = (memwriteM == 2'b11) && (dataadr[2:0] == 3'b000);
        wd_ok_s   = (memwriteM == 2'b01) && (dataadr[1:0] == 2'b00);
        if (state_r == ST_READY) begin
            commit_s = dw_ok_s || wd_ok_s;
            bad_s    = (memwriteM != 2'b00) && !(dw_ok_s || wd_ok_s);
        end else begin
            // Stores during the clear sweep are silently ignored.
            commit_s = 1'b0;
            bad_s    = 1'b0;
        end
        wr_dw_s = commit_s && dw_ok_s;
        wr_lo_s = commit_s && wd_ok_s && !dataadr[2];
        wr_hi_s = commit_s && wd_ok_s && dataadr[2];
    end

    // State register: CLEAR after reset, READY once the sweep finishes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: leave CLEAR on the edge that writes the last entry.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_idx_r == {AW{1'b1}}) begin
                    state_s = ST_READY;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_READY: state_s = ST_READY;
            default:  state_s = ST_CLEAR;
        endcase
    end

    // Output logic: combinational load and debug data, forced to zero while clearing.
    always_comb begin
        readdata = {N{1'b0}};
        dbgdata  = {N{1'b0}};
        case (state_r)
            ST_READY: begin
                dbgdata = mem_r[dbgadr];
                if (dtype) begin
                    readdata = rd_word_s;
                end else if (dataadr[2]) begin
                    readdata = {32'h0000_0000, rd_word_s[63:32]};
                end else begin
                    readdata = {32'h0000_0000, rd_word_s[31:0]};
                end
            end
            ST_CLEAR: begin
                readdata = {N{1'b0}};
                dbgdata  = {N{1'b0}};
            end
            default: begin
                readdata = {N{1'b0}};
                dbgdata  = {N{1'b0}};
            end
        endcase
    end

    // Clear index, registered ready flag, sticky error and saturating store count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_idx_r  <= {AW{1'b0}};
            ready_r    <= 1'b0;
            err_r      <= 1'b0;
            storecnt_r <= 16'h0000;
        end else begin
            ready_r <= (state_s == ST_READY);
            if (state_r == ST_CLEAR) begin
                clr_idx_r <= clr_idx_r + AW'(1'b1);
            end
            if (bad_s) begin
                err_r <= 1'b1;
            end
            if (commit_s && (storecnt_r != 16'hFFFF)) begin
                storecnt_r <= storecnt_r + 16'h0001;
            end
        end
    end

    // Storage array: zero sweep during CLEAR, lane-selective stores in READY.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem_r[clr_idx_r] <= {N{1'b0}};
        end else if (wr_dw_s) begin
            mem_r[idx_s] <= writedata;
        end else if (wr_lo_s) begin
            mem_r[idx_s][31:0] <= writedata[31:0];
        end else if (wr_hi_s) begin
            mem_r[idx_s][63:32] <= writedata[31:0];
        end
    end

    assign ready    = ready_r;
    assign err      = err_r;
    assign storecnt = storecnt_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: randomized and directed accesses
// against a byte-addressed reference model, with a queue-based scoreboard.
module tb_dmem_responder;

    localparam int N     = 64;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int BYTES = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  dataadr;
    logic [N-1:0]  writedata;
    logic [1:0]    memwriteM;
    logic          dtype;
    logic [N-1:0]  readdata;
    logic          ready;
    logic          err;
    logic [15:0]   storecnt;
    logic [AW-1:0] dbgadr;
    logic [N-1:0]  dbgdata;

    always #5 clk = ~clk;

    dmem_responder #(.N(N), .AW(AW)) dut (
        .clk(clk), .reset(reset), .dataadr(dataadr), .writedata(writedata),
        .memwriteM(memwriteM), .dtype(dtype), .readdata(readdata),
        .ready(ready), .err(err), .storecnt(storecnt),
        .dbgadr(dbgadr), .dbgdata(dbgdata)
    );

    typedef struct {
        int          sel;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Reference model: plain byte memory plus counters.
    logic [7:0] mb [BYTES];
    int  clr_cnt;
    bit  in_rst;
    bit  m_err;
    int  m_cnt;

    function automatic bit m_ready();
        return !in_rst && (clr_cnt >= DEPTH);
    endfunction

    function automatic logic [63:0] rd_bytes(int base, int n);
        logic [63:0] r = 64'h0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = mb[(base + k) % BYTES];
        return r;
    endfunction

    function automatic logic [63:0] m_load(logic [63:0] a, logic dt);
        int b = int'(a[8:0]);
        if (!m_ready()) return 64'h0;
        if (dt) return rd_bytes(b - (b % 8), 8);
        return rd_bytes(b - (b % 4), 4);
    endfunction

    task automatic model_reset();
        in_rst = 1'b1;
        clr_cnt = 0;
        m_err = 1'b0;
        m_cnt = 0;
        for (int i = 0; i < BYTES; i++) mb[i] = 8'h00;
    endtask

    // One clock cycle: drive, predict, cross the edge, update model.
    task automatic cycle(input logic [63:0] a, input logic [63:0] wd,
                         input logic [1:0] we, input logic dt, input int dbg);
        exp_t e;
        int   b;
        bit   ok;
        dataadr = a; writedata = wd; memwriteM = we; dtype = dt;
        dbgadr = AW'(dbg);
        e.sel = 0; e.exp = m_load(a, dt);                          e.name = "readdata"; q.push_back(e);
        e.sel = 1; e.exp = m_ready() ? rd_bytes((dbg % DEPTH) * 8, 8) : 64'h0;
                                                                   e.name = "dbgdata";  q.push_back(e);
        e.sel = 2; e.exp = {63'h0, m_ready()};                     e.name = "ready";    q.push_back(e);
        e.sel = 3; e.exp = {63'h0, m_err};                         e.name = "err";      q.push_back(e);
        e.sel = 4; e.exp = 64'(m_cnt);                             e.name = "storecnt"; q.push_back(e);
        @(posedge clk);
        if (!in_rst) begin
            if (clr_cnt >= DEPTH) begin
                if (we != 2'b00) begin
                    b  = int'(a[8:0]);
                    ok = ((we == 2'b11) && (b % 8 == 0)) || ((we == 2'b01) && (b % 4 == 0));
                    if (ok) begin
                        for (int k = 0; k < ((we == 2'b11) ? 8 : 4); k++)
                            mb[(b + k) % BYTES] = wd[8*k +: 8];
                        if (m_cnt < 65535) m_cnt++;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end else begin
                clr_cnt++;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(64'h0, 64'h0, 2'b00, 1'b1, i);
    endtask

    // Monitor: compare everything the stimulus predicted for this cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [63:0] act;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.sel)
                0: act = readdata;
                1: act = dbgdata;
                2: act = {63'h0, ready};
                3: act = {63'h0, err};
                4: act = {48'h0, storecnt};
                default: act = 64'hx;
            endcase
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s at %0t: got %h expected %h", e.name, $time, act, e.exp);
            end
        end
    end

    initial begin
        logic [63:0] a;
        logic [1:0]  we;
        int          r;
        reset = 1'b0;
        dataadr = 64'h0; writedata = 64'h0; memwriteM = 2'b00; dtype = 1'b0; dbgadr = '0;
        model_reset();
        @(posedge clk); #1;
        idle(2);
        reset = 1'b1; in_rst = 1'b0;

        // Clear sweep: ready low for exactly 64 cycles, debug reads zero.
        idle(DEPTH + 1);
        for (int i = 0; i < DEPTH; i++) cycle(64'h0, 64'h0, 2'b00, 1'b0, i);

        // Directed doubleword and word stores.
        cycle(64'h10, 64'h1122334455667788, 2'b11, 1'b1, 2);
        cycle(64'h10, 64'h0, 2'b00, 1'b1, 2);
        cycle(64'h14, 64'h0, 2'b00, 1'b0, 2);
        cycle(64'h14, 64'h00000000DEADBEEF, 2'b01, 1'b1, 2);
        cycle(64'h10, 64'h0, 2'b00, 1'b1, 2);
        // Misaligned and reserved strobes.
        cycle(64'h12, 64'hAAAAAAAA55555555, 2'b01, 1'b1, 2);
        cycle(64'h0C, 64'hAAAAAAAA55555555, 2'b11, 1'b1, 1);
        cycle(64'h10, 64'hAAAAAAAA55555555, 2'b10, 1'b1, 2);
        cycle(64'h10, 64'h0, 2'b00, 1'b1, 2);
        // Aliasing beyond the array span.
        cycle(64'h208, 64'hCAFEF00D12345678, 2'b11, 1'b1, 1);
        cycle(64'h8, 64'h0, 2'b00, 1'b1, 1);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 9);
            we = (r < 4) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b11 : 2'b10;
            a = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) a = (we == 2'b01) ? (a & ~64'h3) : (a & ~64'h7);
            cycle(a, {$urandom, $urandom}, we, 1'($urandom), $urandom_range(0, DEPTH - 1));
        end

        // Reset mid-READY: outputs drop immediately, sweep restarts.
        reset = 1'b0; model_reset();
        idle(2);
        reset = 1'b1; in_rst = 1'b0;
        cycle(64'h10, 64'h1, 2'b11, 1'b1, 2);
        idle(DEPTH + 2);

        // Reset mid-CLEAR at index 30.
        reset = 1'b0; model_reset();
        idle(1);
        reset = 1'b1; in_rst = 1'b0;
        idle(30);
        reset = 1'b0; model_reset();
        idle(1);
        reset = 1'b1; in_rst = 1'b0;
        idle(DEPTH + 2);

        // Saturate the store counter, then one more store.
        while (m_cnt < 65535) cycle(64'h18, 64'($urandom), 2'b11, 1'b1, 3);
        cycle(64'h20, 64'h0123456789ABCDEF, 2'b11, 1'b1, 4);
        cycle(64'h20, 64'h0, 2'b00, 1'b1, 4);

        @(negedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
